pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage pipeline. Consumes the decoded opcode/funct fields, register numbers and EX-stage status, and drives the enable (`En`) and active-low clear (`Clrn`) inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Covers three cases:
- load-use bubbles;
- taken-branch flushes;
- a multi-cycle divide hold tracked by an internal FSM and counter.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/haz_div_timer.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: divide decode
// constants and the controller state encoding.
package pipe_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    typedef enum logic {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } haz_state_e;

    function automatic logic is_div(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_SPECIAL) && ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU));
    endfunction

endpackage

// File: rtl/haz_div_timer.sv
// Divide occupancy down-counter: loads on divide entry, counts down while the
// controller waits, and flags the final (release) cycle.
module haz_div_timer (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic       active,
    input  logic [7:0] load_val,
    output logic [7:0] cnt,
    output logic       zero,
    output logic       done
);

    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = load_val;
        end else if (active && (cnt_reg != 8'd0)) begin
            cnt_next = cnt_reg - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= 8'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt  = cnt_reg;
    assign zero = (cnt_reg == 8'd0);
    // Reset in the last cycle abandons the divide without a completion pulse.
    assign done = active && zero && !srst;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / taken-branch / multi-cycle divide stall controller for the
// 5-stage pipeline. Optional saturating perf counters: HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_LAT = 32,
    parameter int PERF_W  = 32
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] ID_Op,
    input  logic [5:0] ID_Funct,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    input  logic       EX_Load,
    input  logic [4:0] EX_Rt,
    input  logic       EX_BrTaken,
    output logic       PC_En,
    output logic       IFID_En,
    output logic       IFID_Clrn,
    output logic       IDEX_En,
    output logic       IDEX_Clrn,
    output logic       EXMEM_En,
    output logic       Div_Busy,
    output logic       Div_Done
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] Perf_Stall,
    output logic [PERF_W-1:0] Perf_Flush
`endif
);

    localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 1);

    haz_state_e state_reg;
    haz_state_e state_next;
    logic       div_load;
    logic       div_zero;
    logic [7:0] div_cnt;
    logic       flush_fire;
    logic       lu;
    logic       isdiv;

    assign isdiv = is_div(ID_Op, ID_Funct);
    assign lu    = EX_Load && (EX_Rt != 5'd0) &&
                   ((ID_UsesRs && (ID_Rs == EX_Rt)) || (ID_UsesRt && (ID_Rt == EX_Rt)));

    haz_div_timer u_timer (
        .clk      (Clk),
        .srst     (Rst),
        .load     (div_load),
        .active   (state_reg == DIV_WAIT),
        .load_val (DIV_LOAD),
        .cnt      (div_cnt),
        .zero     (div_zero),
        .done     (Div_Done)
    );

    always_comb begin
        PC_En      = 1'b0;
        IFID_En    = 1'b0;
        IFID_Clrn  = 1'b0;
        IDEX_En    = 1'b0;
        IDEX_Clrn  = 1'b0;
        EXMEM_En   = 1'b0;
        Div_Busy   = 1'b0;
        div_load   = 1'b0;
        flush_fire = 1'b0;
        state_next = state_reg;
        if (Rst) begin
            state_next = RUN;
        end else begin
            case (state_reg)
                RUN: begin
                    if (EX_BrTaken) begin
                        {PC_En, IFID_En, IDEX_En, EXMEM_En} = 4'b1111;
                        flush_fire = 1'b1;
                    end else if (lu) begin
                        // Hold PC and IF/ID; inject a bubble into ID/EX.
                        IFID_Clrn = 1'b1;
                        IDEX_En   = 1'b1;
                        EXMEM_En  = 1'b1;
                    end else begin
                        {PC_En, IFID_En, IDEX_En, EXMEM_En} = 4'b1111;
                        {IFID_Clrn, IDEX_Clrn}              = 2'b11;
                        if (isdiv) begin
                            div_load   = 1'b1;
                            state_next = DIV_WAIT;
                        end
                    end
                end
                DIV_WAIT: begin
                    {IFID_Clrn, IDEX_Clrn} = 2'b11;
                    Div_Busy               = 1'b1;
                    if (div_zero) begin
                        {PC_En, IFID_En, IDEX_En, EXMEM_En} = 4'b1111;
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    logic unused_cnt;
    assign unused_cnt = ^div_cnt;

`ifdef HAZ_PERF_CNT_EN
    logic [1:0]        perf_inc;
    logic [PERF_W-1:0] perf_reg [2];

    assign perf_inc = {flush_fire, !PC_En && !Rst};

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        always_ff @(posedge Clk) begin
            if (Rst) begin
                perf_reg[gi] <= '0;
            end else if (perf_inc[gi] && !(&perf_reg[gi])) begin
                perf_reg[gi] <= perf_reg[gi] + 1'b1;
            end
        end
    end

    assign Perf_Stall = perf_reg[0];
    assign Perf_Flush = perf_reg[1];
`else
    logic unused_perf;
    assign unused_perf = flush_fire ^ (PERF_W > 0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: hand-written vector table for the corner cases,
// then randomized traffic against an occupancy-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;

    localparam logic [7:0] O_RST  = 8'h00;
    localparam logic [7:0] O_RUN  = 8'hFC;
    localparam logic [7:0] O_LU   = 8'h34;
    localparam logic [7:0] O_BR   = 8'hD4;
    localparam logic [7:0] O_HOLD = 8'h2A;
    localparam logic [7:0] O_DONE = 8'hFF;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       ld;
        logic [4:0] ert;
        logic       br;
    } in_t;

    typedef struct {
        in_t        in;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] id_op = '0, id_funct = '0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_load = 1'b0, ex_br = 1'b0;
    logic       pc_en, ifid_en, ifid_clrn, idex_en, idex_clrn, exmem_en, div_busy, div_done;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] perf_stall, perf_flush;
`endif

    int n_vec = 0;
    int n_err = 0;
    int div_left = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DIV_LAT(LAT), .PERF_W(16)) dut (
        .Clk        (clk),
        .Rst        (rst),
        .ID_Op      (id_op),
        .ID_Funct   (id_funct),
        .ID_Rs      (id_rs),
        .ID_Rt      (id_rt),
        .ID_UsesRs  (id_uses_rs),
        .ID_UsesRt  (id_uses_rt),
        .EX_Load    (ex_load),
        .EX_Rt      (ex_rt),
        .EX_BrTaken (ex_br),
        .PC_En      (pc_en),
        .IFID_En    (ifid_en),
        .IFID_Clrn  (ifid_clrn),
        .IDEX_En    (idex_en),
        .IDEX_Clrn  (idex_clrn),
        .EXMEM_En   (exmem_en),
        .Div_Busy   (div_busy),
        .Div_Done   (div_done)
`ifdef HAZ_PERF_CNT_EN
        ,
        .Perf_Stall (perf_stall),
        .Perf_Flush (perf_flush)
`endif
    );

    function automatic in_t mk(logic r, logic [5:0] op, logic [5:0] fn, logic [4:0] rs,
                               logic [4:0] rt, logic urs, logic urt, logic ld,
                               logic [4:0] ert, logic br);
        in_t x;
        x = '{rst: r, op: op, funct: fn, rs: rs, rt: rt, urs: urs, urt: urt,
              ld: ld, ert: ert, br: br};
        return x;
    endfunction

    // Reference: div_left counts remaining cycles the divide holds EX
    // (LAT..1); the last one is the release cycle.
    function automatic logic is_lu(in_t x);
        return x.ld && (x.ert != 0) &&
               ((x.urs && x.rs == x.ert) || (x.urt && x.rt == x.ert));
    endfunction

    function automatic logic is_dv(in_t x);
        return (x.op == 6'd0) && (x.funct == 6'h1A || x.funct == 6'h1B);
    endfunction

    function automatic logic [7:0] model_out(in_t x, int left);
        if (x.rst)     return O_RST;
        if (left > 1)  return O_HOLD;
        if (left == 1) return O_DONE;
        if (x.br)      return O_BR;
        if (is_lu(x))  return O_LU;
        return O_RUN;
    endfunction

    function automatic int model_next(in_t x, int left);
        if (x.rst)    return 0;
        if (left > 0) return left - 1;
        if (!x.br && !is_lu(x) && is_dv(x)) return LAT;
        return 0;
    endfunction

    task automatic apply(input in_t x, input logic [7:0] exp, input string nm);
        logic [7:0] got;
        @(negedge clk);
        rst        = x.rst;
        id_op      = x.op;
        id_funct   = x.funct;
        id_rs      = x.rs;
        id_rt      = x.rt;
        id_uses_rs = x.urs;
        id_uses_rt = x.urt;
        ex_load    = x.ld;
        ex_rt      = x.ert;
        ex_br      = x.br;
        #1;
        got = {pc_en, ifid_en, ifid_clrn, idex_en, idex_clrn, exmem_en, div_busy, div_done};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: vec %0d outputs=%b expected=%b", nm, n_vec, got, exp);
        end else begin
            $display("vec %0d %s outputs=%b", n_vec, nm, got);
        end
        div_left = model_next(x, div_left);
    endtask

    vec_t tbl[$];

    initial begin
        in_t idle, lu5, ludv, lurt, nouse, lu0, brall, dv, dvu, rnd;

        idle  = mk(0, 6'h08, 6'h00, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0);
        lu5   = mk(0, 6'h08, 6'h00, 5'd5, 5'd2, 1, 0, 1, 5'd5, 0);
        lu0   = mk(0, 6'h08, 6'h00, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0);
        lurt  = mk(0, 6'h08, 6'h00, 5'd1, 5'd7, 1, 1, 1, 5'd7, 0);
        nouse = mk(0, 6'h08, 6'h00, 5'd5, 5'd2, 0, 0, 1, 5'd5, 0);
        brall = mk(0, 6'h00, 6'h1A, 5'd5, 5'd2, 1, 1, 1, 5'd5, 1);
        dv    = mk(0, 6'h00, 6'h1A, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0);
        dvu   = mk(0, 6'h00, 6'h1B, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0);
        ludv  = mk(0, 6'h00, 6'h1A, 5'd5, 5'd2, 1, 1, 1, 5'd5, 0);

        tbl.push_back('{mk(1, 6'h00, 6'h1A, 5'd5, 5'd5, 1, 1, 1, 5'd5, 1), O_RST, "rst_a"});
        tbl.push_back('{mk(1, 6'h08, 6'h00, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0), O_RST, "rst_b"});
        tbl.push_back('{idle,  O_RUN,  "post_rst"});
        tbl.push_back('{lu5,   O_LU,   "lu_rs"});
        tbl.push_back('{idle,  O_RUN,  "lu_bubble"});
        tbl.push_back('{lu0,   O_RUN,  "lu_r0"});
        tbl.push_back('{lurt,  O_LU,   "lu_rt"});
        tbl.push_back('{nouse, O_RUN,  "lu_unused"});
        tbl.push_back('{brall, O_BR,   "br_prio"});
        tbl.push_back('{idle,  O_RUN,  "br_stays_run"});
        tbl.push_back('{dv,    O_RUN,  "div_enter"});
        tbl.push_back('{idle,  O_HOLD, "div_hold1"});
        tbl.push_back('{brall, O_HOLD, "div_hold2_ign"});
        tbl.push_back('{idle,  O_HOLD, "div_hold3"});
        tbl.push_back('{dvu,   O_DONE, "div_done_dvu"});
        tbl.push_back('{dvu,   O_RUN,  "divu_enter"});
        tbl.push_back('{idle,  O_HOLD, "divu_hold1"});
        tbl.push_back('{idle,  O_HOLD, "divu_hold2"});
        tbl.push_back('{idle,  O_HOLD, "divu_hold3"});
        tbl.push_back('{idle,  O_DONE, "divu_done"});
        tbl.push_back('{idle,  O_RUN,  "divu_after"});
        tbl.push_back('{dv,    O_RUN,  "div2_enter"});
        tbl.push_back('{idle,  O_HOLD, "div2_hold1"});
        tbl.push_back('{mk(1, 6'h08, 6'h00, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0), O_RST, "div2_rst"});
        tbl.push_back('{idle,  O_RUN,  "post_rst_div"});
        tbl.push_back('{idle,  O_RUN,  "post_rst_div2"});
        tbl.push_back('{ludv,  O_LU,   "lu_with_div"});
        tbl.push_back('{idle,  O_RUN,  "div_not_entered"});

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].in, tbl[k].exp, tbl[k].nm);
`ifdef HAZ_PERF_CNT_EN
            if (tbl[k].nm == "post_rst_div") begin
                n_vec++;
                if (perf_stall !== 16'd0) begin
                    n_err++;
                    $display("FAIL perf_stall_rst: got=%0d expected=0", perf_stall);
                end
            end
`endif
        end

        for (int k = 0; k < 400; k++) begin
            rnd.rst   = ($urandom_range(0, 31) == 0);
            rnd.op    = ($urandom_range(0, 2) != 0) ? 6'd0 : 6'($urandom_range(1, 63));
            case ($urandom_range(0, 3))
                0:       rnd.funct = 6'h1A;
                1:       rnd.funct = 6'h1B;
                default: rnd.funct = 6'($urandom_range(0, 63));
            endcase
            rnd.rs    = 5'($urandom_range(0, 3));
            rnd.rt    = 5'($urandom_range(0, 3));
            rnd.urs   = 1'($urandom_range(0, 1));
            rnd.urt   = 1'($urandom_range(0, 1));
            rnd.ld    = 1'($urandom_range(0, 1));
            rnd.ert   = 5'($urandom_range(0, 3));
            rnd.br    = ($urandom_range(0, 7) == 0);
            apply(rnd, model_out(rnd, div_left), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
